// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension stage with valid/ready handshake and a 2-entry skid buffer.
// Optional IMM_EXT_BYPASS_EN: zero-latency pass-through when the buffer is empty.
module imm_ext_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [2:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  localparam int PAD_W = DATA_W - IMM_W;

  // O is the output register, K the skid register; the state encodes their valid bits.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   o_data_q, o_data_d, k_data_q, k_data_d;
  logic [TAG_W-1:0]    o_tag_q, o_tag_d, k_tag_q, k_tag_d;
  logic                o_err_q, o_err_d, k_err_q, k_err_d;

  logic [DATA_W-1:0]   sext;
  logic [DATA_W-1:0]   ext_data;
  logic                ext_err;
  logic                o_valid;
  logic                accept;
  logic                consume;

  assign sext = {{PAD_W{in_imm[IMM_W-1]}}, in_imm};

  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (in_mode)
      3'b000:  ext_data = {{PAD_W{1'b0}}, in_imm};
      3'b001:  ext_data = sext;
      3'b010:  ext_data = {in_imm, {PAD_W{1'b0}}};
      3'b011:  ext_data = sext << 2;
      3'b100:  ext_data = {{PAD_W{1'b1}}, in_imm};
      default: ext_err  = 1'b1;
    endcase
  end

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // the producer holds its payload stable until then, and ready never depends on valid.
  assign o_valid  = (state_q != ST_EMPTY);
  assign in_ready = (state_q != ST_FULL);

`ifdef IMM_EXT_BYPASS_EN
  logic bypass;
  assign bypass    = (state_q == ST_EMPTY) && in_valid;
  assign out_valid = o_valid || bypass;
  assign out_data  = bypass ? ext_data : o_data_q;
  assign out_tag   = bypass ? in_tag   : o_tag_q;
  assign out_err   = bypass ? ext_err  : o_err_q;
`else
  assign out_valid = o_valid;
  assign out_data  = o_data_q;
  assign out_tag   = o_tag_q;
  assign out_err   = o_err_q;
`endif

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    o_data_d = o_data_q;
    o_tag_d  = o_tag_q;
    o_err_d  = o_err_q;
    k_data_d = k_data_q;
    k_tag_d  = k_tag_q;
    k_err_d  = k_err_q;
    case (state_q)
      // In EMPTY, consume can only be true for a bypassed entry, which is then not stored.
      ST_EMPTY: begin
        if (accept && !consume) begin
          state_d  = ST_ONE;
          o_data_d = ext_data;
          o_tag_d  = in_tag;
          o_err_d  = ext_err;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          o_data_d = ext_data;
          o_tag_d  = in_tag;
          o_err_d  = ext_err;
        end else if (accept) begin
          state_d  = ST_FULL;
          k_data_d = ext_data;
          k_tag_d  = in_tag;
          k_err_d  = ext_err;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (consume) begin
          state_d  = ST_ONE;
          o_data_d = k_data_q;
          o_tag_d  = k_tag_q;
          o_err_d  = k_err_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      o_data_q <= '0;
      o_tag_q  <= '0;
      o_err_q  <= 1'b0;
      k_data_q <= '0;
      k_tag_q  <= '0;
      k_err_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      o_data_q <= o_data_d;
      o_tag_q  <= o_tag_d;
      o_err_q  <= o_err_d;
      k_data_q <= k_data_d;
      k_tag_q  <= k_tag_d;
      k_err_q  <= k_err_d;
    end
  end

endmodule
